capture_core: RTL and testbench

- Input-capture counterpart to the timer core: it measures an elapsed interval instead of generating one.
- Counts prescaled clock ticks between two edges on an external signal and presents the result as a captured count.
- Sits beside the timer core under the same register-interface wrapper, which drives the config/arm/abort inputs and reads capture/status.
- Used for pulse-width and period measurement of slow external signals, such as button or touch inputs.

---
 rtl/capture_core.sv | 224 ++++++++++++++++++++++
 tb/tb_capture_core.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/capture_core.sv
// capture_core: input-capture block. Counts prescaled clock ticks between a
// selected start edge and the matching end edge on an asynchronous input.
// Pulse-width mode ends on the opposite edge, period mode on the same edge.
// Optional feature macro: CAPTURE_TIMEOUT_EN adds timeout_init / timed_out and
// a tick counter that abandons a measurement that takes too long.
//
// Handshake: arm and abort are single-cycle strobes sampled on the rising
// clock edge. arm is accepted only in IDLE when abort is low. abort wins
// over arm and over any edge detected in the same cycle. capture_valid is a
// level that stays high until the next accepted arm.
module capture_core #(
  parameter int CTR_WIDTH   = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          prescaler_init,
  input  logic                 edge_sel,
  input  logic                 mode,
  input  logic                 sig_in,
  input  logic                 arm,
  input  logic                 abort,
`ifdef CAPTURE_TIMEOUT_EN
  input  logic [31:0]          timeout_init,
  output logic                 timed_out,
`endif
  output logic [CTR_WIDTH-1:0] capture,
  output logic                 capture_valid,
  output logic                 overflow,
  output logic                 busy,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_START = 2'd1,
    MEASURE    = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic [31:0]            pinit_q, pinit_d;
  logic                   edge_sel_q, edge_sel_d;
  logic                   mode_q, mode_d;
  logic [31:0]            presc_q, presc_d;
  logic [CTR_WIDTH-1:0]   count_q, count_d;
  logic [CTR_WIDTH-1:0]   capture_q, capture_d;
  logic                   valid_q, valid_d;
  logic                   ovf_q, ovf_d;
`ifdef CAPTURE_TIMEOUT_EN
  logic [31:0]            to_init_q, to_init_d;
  logic [31:0]            to_cnt_q, to_cnt_d;
  logic                   timed_out_q, timed_out_d;
`endif

  logic                   sig_s;
  logic                   rise, fall;
  logic                   start_edge, end_edge;
  logic                   tick;
  logic                   count_full;
  logic [CTR_WIDTH-1:0]   count_next;
  logic                   timeout_hit;

  // Synchronizer shift chain plus one history flop; both edge polarities see
  // the same SYNC_STAGES+1 cycle latency so the interval is not skewed.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};
    hist_d = sig_s;
  end

  assign sig_s      = sync_q[SYNC_STAGES-1];
  assign rise       = sig_s & ~hist_q;
  assign fall       = ~sig_s & hist_q;
  assign start_edge = edge_sel_q ? fall : rise;
  // End on falling when (start rising, width) or (start falling, period).
  assign end_edge   = (edge_sel_q ^ ~mode_q) ? fall : rise;

  assign tick       = (presc_q == pinit_q);
  assign count_full = (count_q == {CTR_WIDTH{1'b1}});
  assign count_next = (tick && !count_full) ? count_q + 1'b1 : count_q;

`ifdef CAPTURE_TIMEOUT_EN
  assign timeout_hit = (to_init_q != 32'd0) && tick && ((to_cnt_q + 32'd1) == to_init_q);
`else
  assign timeout_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; abort has priority, an end edge beats a timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:       if (arm && !abort) state_d = WAIT_START;
      WAIT_START: begin
        if (abort)            state_d = IDLE;
        else if (timeout_hit) state_d = IDLE;
        else if (start_edge)  state_d = MEASURE;
      end
      MEASURE:    begin
        if (abort)                        state_d = IDLE;
        else if (end_edge || timeout_hit) state_d = IDLE;
      end
      default:    state_d = IDLE;
    endcase
  end

  // Datapath and output next values for each state.
  always_comb begin
    pinit_d    = pinit_q;
    edge_sel_d = edge_sel_q;
    mode_d     = mode_q;
    presc_d    = presc_q;
    count_d    = count_q;
    capture_d  = capture_q;
    valid_d    = valid_q;
    ovf_d      = ovf_q;
`ifdef CAPTURE_TIMEOUT_EN
    to_init_d   = to_init_q;
    to_cnt_d    = to_cnt_q;
    timed_out_d = timed_out_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (arm && !abort) begin
          pinit_d    = prescaler_init;
          edge_sel_d = edge_sel;
          mode_d     = mode;
          presc_d    = 32'd0;
          count_d    = '0;
          valid_d    = 1'b0;
          ovf_d      = 1'b0;
`ifdef CAPTURE_TIMEOUT_EN
          to_init_d   = timeout_init;
          to_cnt_d    = 32'd0;
          timed_out_d = 1'b0;
`endif
        end
      end
      WAIT_START: begin
        if (!abort) begin
          // Prescaler free-runs here only to pace the timeout counter.
          presc_d = tick ? 32'd0 : presc_q + 32'd1;
`ifdef CAPTURE_TIMEOUT_EN
          if (tick) to_cnt_d = to_cnt_q + 32'd1;
          if (timeout_hit) timed_out_d = 1'b1;
`endif
          if (start_edge && !timeout_hit) begin
            presc_d = 32'd0;
            count_d = '0;
          end
        end
      end
      MEASURE: begin
        if (!abort) begin
          presc_d = tick ? 32'd0 : presc_q + 32'd1;
          count_d = count_next;
          if (tick && count_full) ovf_d = 1'b1;
`ifdef CAPTURE_TIMEOUT_EN
          if (tick) to_cnt_d = to_cnt_q + 32'd1;
          if (timeout_hit && !end_edge) timed_out_d = 1'b1;
`endif
          if (end_edge) begin
            capture_d = count_next;
            valid_d   = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q     <= '0;
      hist_q     <= 1'b0;
      pinit_q    <= 32'd0;
      edge_sel_q <= 1'b0;
      mode_q     <= 1'b0;
      presc_q    <= 32'd0;
      count_q    <= '0;
      capture_q  <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
`ifdef CAPTURE_TIMEOUT_EN
      to_init_q   <= 32'd0;
      to_cnt_q    <= 32'd0;
      timed_out_q <= 1'b0;
`endif
    end else begin
      sync_q     <= sync_d;
      hist_q     <= hist_d;
      pinit_q    <= pinit_d;
      edge_sel_q <= edge_sel_d;
      mode_q     <= mode_d;
      presc_q    <= presc_d;
      count_q    <= count_d;
      capture_q  <= capture_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
`ifdef CAPTURE_TIMEOUT_EN
      to_init_q   <= to_init_d;
      to_cnt_q    <= to_cnt_d;
      timed_out_q <= timed_out_d;
`endif
    end
  end

  assign capture       = capture_q;
  assign capture_valid = valid_q;
  assign overflow      = ovf_q;
  assign busy          = (state_q != IDLE);
  assign dbg_state     = state_q;
`ifdef CAPTURE_TIMEOUT_EN
  assign timed_out     = timed_out_q;
`endif

endmodule

// File: tb/tb_capture_core.sv
// tb_capture_core: directed bench for capture_core (CTR_WIDTH=8 so the
// saturation case stays short). Expected {overflow, capture} pairs are queued
// when a measurement is launched; a monitor pops one on each rising edge of
// capture_valid. Build with +define+CAPTURE_TIMEOUT_EN to cover the timeout.
module tb_capture_core;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [31:0]  prescaler_init = 32'd0;
  logic         edge_sel = 1'b0;
  logic         mode = 1'b0;
  logic         sig_in = 1'b0;
  logic         arm = 1'b0;
  logic         abort = 1'b0;
`ifdef CAPTURE_TIMEOUT_EN
  logic [31:0]  timeout_init = 32'd0;
  logic         timed_out;
`endif
  logic [W-1:0] capture;
  logic         capture_valid;
  logic         overflow;
  logic         busy;
  logic [1:0]   dbg_state;

  logic [W:0]   exp_q[$];
  int           n_checks = 0;
  int           n_fail = 0;
  logic         prev_valid = 1'b0;

  capture_core #(.CTR_WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .prescaler_init(prescaler_init),
    .edge_sel(edge_sel), .mode(mode), .sig_in(sig_in),
    .arm(arm), .abort(abort),
`ifdef CAPTURE_TIMEOUT_EN
    .timeout_init(timeout_init), .timed_out(timed_out),
`endif
    .capture(capture), .capture_valid(capture_valid),
    .overflow(overflow), .busy(busy), .dbg_state(dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input logic [31:0] p, input logic es, input logic md);
    prescaler_init = p;
    edge_sel = es;
    mode = md;
    arm = 1'b1;
    step(1);
    arm = 1'b0;
    prescaler_init = 32'hFFFF_FFFF;  // must be ignored while busy
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy && k < budget) begin
      step(1);
      k++;
    end
    chk("wait_idle", {63'd0, busy}, 64'd0);
    step(2);
  endtask

  // Rising-start pulse of 'len' cycles, expecting {ovf, cap}.
  task automatic pulse(input logic [31:0] p, input int len, input logic ovf, input logic [W-1:0] cap);
    do_arm(p, 1'b0, 1'b0);
    exp_q.push_back({ovf, cap});
    step(4);
    sig_in = 1'b1;
    step(len);
    sig_in = 1'b0;
    wait_idle(400);
  endtask

  // Monitor: compare each newly presented result against the queue head.
  always @(negedge clk) begin
    if (!reset && capture_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_capture", {55'd0, overflow, capture}, 64'hFFFF);
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        chk("capture_result", {55'd0, overflow, capture}, {55'd0, e});
      end
    end
    prev_valid <= capture_valid;
  end

  initial begin
    // Reset state.
    step(3);
    chk("reset_capture", 64'(capture), 64'd0);
    chk("reset_flags", {60'd0, capture_valid, overflow, busy, 1'b0}, 64'd0);
    chk("reset_state", 64'(dbg_state), 64'd0);
    reset = 1'b0;
    step(2);

    // Unit prescale pulse width, with busy-fall latency after sig_in falls.
    do_arm(32'd0, 1'b0, 1'b0);
    exp_q.push_back({1'b0, 8'd10});
    chk("armed_busy", {63'd0, busy}, 64'd1);
    step(4);
    sig_in = 1'b1;
    step(10);
    sig_in = 1'b0;
    step(2);
    chk("busy_before_end", {63'd0, busy}, 64'd1);
    step(1);
    chk("busy_after_end", {63'd0, busy}, 64'd0);
    chk("valid_after_end", {63'd0, capture_valid}, 64'd1);
    step(2);

    // Prescaled measurements.
    pulse(32'd3, 10, 1'b0, 8'd2);
    pulse(32'd4, 20, 1'b0, 8'd4);

    // Period mode, falling to falling, stray rising edge before arm.
    sig_in = 1'b1;
    step(5);
    do_arm(32'd0, 1'b1, 1'b1);
    exp_q.push_back({1'b0, 8'd20});
    step(4);
    sig_in = 1'b0;
    step(10);
    sig_in = 1'b1;
    step(10);
    sig_in = 1'b0;
    wait_idle(100);

    // Abort mid-measurement keeps the previous capture.
    pulse(32'd0, 10, 1'b0, 8'd10);
    do_arm(32'd0, 1'b0, 1'b0);
    chk("arm_clears_valid", {63'd0, capture_valid}, 64'd0);
    chk("arm_keeps_capture", 64'(capture), 64'd10);
    step(4);
    sig_in = 1'b1;
    step(8);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_valid", {63'd0, capture_valid}, 64'd0);
    chk("abort_capture", 64'(capture), 64'd10);
    sig_in = 1'b0;
    step(6);
    chk("abort_no_late_valid", {63'd0, capture_valid}, 64'd0);
    arm = 1'b1;
    abort = 1'b1;
    step(1);
    arm = 1'b0;
    abort = 1'b0;
    chk("arm_abort_idle", {63'd0, busy}, 64'd0);

    // Saturation.
    pulse(32'd0, 300, 1'b1, 8'd255);
    chk("ovf_level", {63'd0, overflow}, 64'd1);

    // Asynchronous reset between clock edges during MEASURE.
    do_arm(32'd0, 1'b0, 1'b0);
    step(4);
    sig_in = 1'b1;
    step(8);
    chk("measuring_busy", 64'(dbg_state), 64'd2);
    #3;
    reset = 1'b1;
    #1;
    chk("async_rst_capture", 64'(capture), 64'd0);
    chk("async_rst_flags", {61'd0, capture_valid, overflow, busy}, 64'd0);
    sig_in = 1'b0;
    step(2);
    reset = 1'b0;
    step(3);

`ifdef CAPTURE_TIMEOUT_EN
    // Timeout with no edge.
    timeout_init = 32'd50;
    do_arm(32'd0, 1'b0, 1'b0);
    step(47);
    chk("timeout_not_early", {63'd0, busy}, 64'd1);
    wait_idle(100);
    chk("timed_out", {63'd0, timed_out}, 64'd1);
    chk("timeout_valid", {63'd0, capture_valid}, 64'd0);
    timeout_init = 32'd0;
`endif

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
